fpu_seq: RTL and testbench
==========================

# fpu_seq

FPU-side responder for the floating-point decode controller's fpu_go/fpu_valid handshake. Accepts one F-type operation per go pulse, latches operands, starts the matching arithmetic unit, tracks fixed or variable latency, and returns a registered 32-bit result with fpu_valid and the destination select fregwb. Sits between the core's decode/writeback path and the FPU arithmetic units; compares are computed internally.

## Interface
- LAT_ADD, 2: cycles from unit_go to valid res_add (also fsub)
- LAT_MUL, 2: cycles from unit_go to valid res_mul
- LAT_CVT, 1: cycles from unit_go to valid res_cvt
- DIV_TIMEOUT, 64: max cycles waiting for div_done/sqrt_done
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- fpu_go  in  1  start pulse, sampled only in IDLE
- funct7  in  7  operation select
- funct3  in  3  compare subtype
- x1, x2  in  32  operands (x1 is int for fcvt.s.w)
- fpu_valid  out  1  one-cycle result strobe
- fregwb  out  1  1 = result to integer regfile, 0 = to float regfile; valid with fpu_valid
- fpu_result  out  32  result, held until next RESP
- fpu_err  out  1  with fpu_valid: illegal funct7/funct3 or timeout
- busy  out  1  state != IDLE
- u_a, u_b  out  32  latched operands to units
- unit_go  out  5  one-hot {CVT,SQRT,DIV,MUL,ADD}, one-cycle pulse
- unit_sub  out  1  ADD unit subtracts; stable while busy
- unit_ftoi  out  1  CVT direction float->int; stable while busy
- res_add, res_mul, res_div, res_sqrt, res_cvt  in  32  unit results
- div_done, sqrt_done  in  1  variable-latency completion strobes

## Operation
- funct7 decode: 0000000 fadd, 0000100 fsub, 0001000 fmul, 0001100 fdiv, 0101100 fsqrt, 1010000 fcmp (funct3 010 feq, 001 flt, 000 fle), 1100000 fcvt.w.s, 1101000 fcvt.s.w; anything else, or fcmp with other funct3, is illegal.
- fregwb = 1 for fcmp and fcvt.w.s; 0 otherwise (including illegal).
- States: IDLE -> ISSUE on fpu_go (latch x1/x2/funct7/funct3 into u_a/u_b/op regs). ISSUE: pulse unit_go; fixed-latency op -> COUNT, div/sqrt -> WAIT_DONE, fcmp -> CAPTURE compare result -> RESP, illegal -> RESP. COUNT: down-counter loaded LAT-1 in ISSUE; at 0 capture unit result -> RESP. WAIT_DONE: capture on matching done strobe -> RESP; counter reaching DIV_TIMEOUT -> RESP with fpu_err=1, result 0. RESP: fpu_valid=1 one cycle -> IDLE.
- Compare: raw IEEE single, no NaN handling; +0 equals -0; ordering by sign-magnitude. Result 32'd1 true, 32'd0 false.
- Illegal: fpu_result=0, fpu_err=1, fregwb=0.
- fpu_go outside IDLE ignored; done strobes outside WAIT_DONE, or from the non-selected unit, ignored.

## Timing
- Reset: state IDLE; fpu_valid, fregwb, fpu_err, busy, unit_go, unit_sub, unit_ftoi = 0; fpu_result, u_a, u_b = 0; counter 0.
- go sampled at edge ending cycle 0; ISSUE cycle 1; fixed op: capture in cycle 1+LAT, fpu_valid in cycle 2+LAT (fadd default: cycle 4).
- fcmp and illegal: fpu_valid in cycle 3 / cycle 2.
- div/sqrt: done seen in cycle k -> fpu_valid in cycle k+1; done in same cycle as ISSUE is not accepted (WAIT_DONE starts cycle 2).
- Minimum go-to-go spacing: next go accepted in the cycle after RESP.
- Reset mid-operation: next cycle IDLE with all reset values; in-flight unit results discarded.

## Structure
- Package fpu_pkg: funct7/funct3 constants, state enum, unit index localparams for unit_go bits.
- Sub-module fp_cmp: combinational feq/flt/fle on two 32-bit singles, instantiated once.

## Test plan
- fadd x1=3F800000 x2=40000000, go cycle 0 -> unit_go=00001 cycle 1, fpu_valid cycle 4, result=res_add, fregwb=0, unit_sub=0.
- flt x1=BF800000 x2=3F800000 -> fpu_valid cycle 3, result 1, fregwb=1; feq 80000000 vs 00000000 -> result 1.
- fdiv with div_done at cycle 10 -> fpu_valid cycle 11 result=res_div; stray sqrt_done cycle 5 ignored.
- fsqrt, no done -> fpu_valid with fpu_err=1, result 0 after DIV_TIMEOUT cycles in WAIT_DONE.
- funct7=1111111 -> fpu_valid cycle 2, fpu_err=1, result 0; second fpu_go during busy ignored.
- rstn low in COUNT -> IDLE next cycle, outputs zero, no fpu_valid; late done strobe ignored.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared decode constants, FSM state and operation encodings for the FPU sequencer.
// The op decode and unit routing helpers live here so the top stays a plain FSM.
package fpu_pkg;

    localparam logic [6:0] F7_FADD   = 7'b0000000;
    localparam logic [6:0] F7_FSUB   = 7'b0000100;
    localparam logic [6:0] F7_FMUL   = 7'b0001000;
    localparam logic [6:0] F7_FDIV   = 7'b0001100;
    localparam logic [6:0] F7_FSQRT  = 7'b0101100;
    localparam logic [6:0] F7_FCMP   = 7'b1010000;
    localparam logic [6:0] F7_FCVTWS = 7'b1100000;
    localparam logic [6:0] F7_FCVTSW = 7'b1101000;

    localparam logic [2:0] F3_FEQ = 3'b010;
    localparam logic [2:0] F3_FLT = 3'b001;
    localparam logic [2:0] F3_FLE = 3'b000;

    // Bit positions inside unit_go, LSB first: {CVT,SQRT,DIV,MUL,ADD}
    localparam int UNIT_ADD  = 0;
    localparam int UNIT_MUL  = 1;
    localparam int UNIT_DIV  = 2;
    localparam int UNIT_SQRT = 3;
    localparam int UNIT_CVT  = 4;
    localparam int N_UNITS   = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_COUNT,
        S_WAIT_DONE,
        S_CAPTURE,
        S_RESP
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_DIV,
        OP_SQRT,
        OP_FEQ,
        OP_FLT,
        OP_FLE,
        OP_CVTWS,
        OP_CVTSW,
        OP_ILL
    } op_e;

    function automatic op_e decode_op(input logic [6:0] f7, input logic [2:0] f3);
        op_e op;
        op = OP_ILL;
        case (f7)
            F7_FADD:   op = OP_ADD;
            F7_FSUB:   op = OP_SUB;
            F7_FMUL:   op = OP_MUL;
            F7_FDIV:   op = OP_DIV;
            F7_FSQRT:  op = OP_SQRT;
            F7_FCVTWS: op = OP_CVTWS;
            F7_FCVTSW: op = OP_CVTSW;
            F7_FCMP: begin
                case (f3)
                    F3_FEQ:  op = OP_FEQ;
                    F3_FLT:  op = OP_FLT;
                    F3_FLE:  op = OP_FLE;
                    default: op = OP_ILL;
                endcase
            end
            default:   op = OP_ILL;
        endcase
        return op;
    endfunction

    // Compares and illegal ops start no external unit.
    function automatic logic [N_UNITS-1:0] unit_mask(input op_e op);
        logic [N_UNITS-1:0] m;
        m = '0;
        case (op)
            OP_ADD, OP_SUB:     m[UNIT_ADD]  = 1'b1;
            OP_MUL:             m[UNIT_MUL]  = 1'b1;
            OP_DIV:             m[UNIT_DIV]  = 1'b1;
            OP_SQRT:            m[UNIT_SQRT] = 1'b1;
            OP_CVTWS, OP_CVTSW: m[UNIT_CVT]  = 1'b1;
            default:            m = '0;
        endcase
        return m;
    endfunction

    function automatic logic writes_int(input op_e op);
        return (op == OP_FEQ) || (op == OP_FLT) || (op == OP_FLE) || (op == OP_CVTWS);
    endfunction

endpackage

// File: rtl/fp_cmp.sv
// Combinational single-precision compare on raw bit patterns: sign-magnitude
// ordering, +0 equal to -0, NaNs ordered like any other pattern.
module fp_cmp (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        eq,
    output logic        lt,
    output logic        le
);

    logic a_zero;
    logic b_zero;

    always_comb begin
        a_zero = (a[30:0] == 31'd0);
        b_zero = (b[30:0] == 31'd0);
        eq     = (a == b) || (a_zero && b_zero);
        lt     = 1'b0;
        if (!(a_zero && b_zero)) begin
            if (a[31] != b[31]) begin
                lt = a[31];
            end else if (!a[31]) begin
                lt = (a[30:0] < b[30:0]);
            end else begin
                // Both negative: larger magnitude is the smaller value
                lt = (b[30:0] < a[30:0]);
            end
        end
        le = lt || eq;
    end

endmodule

// File: rtl/fpu_seq.sv
// FPU-side responder: accepts one F-type op per fpu_go, drives the arithmetic
// units, waits out fixed or variable latency and returns a registered result.
module fpu_seq
    import fpu_pkg::*;
#(
    parameter int LAT_ADD     = 2,
    parameter int LAT_MUL     = 2,
    parameter int LAT_CVT     = 1,
    parameter int DIV_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        fpu_go,
    input  logic [6:0]  funct7,
    input  logic [2:0]  funct3,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        fpu_valid,
    output logic        fregwb,
    output logic [31:0] fpu_result,
    output logic        fpu_err,
    output logic        busy,
    output logic [31:0] u_a,
    output logic [31:0] u_b,
    output logic [4:0]  unit_go,
    output logic        unit_sub,
    output logic        unit_ftoi,
    input  logic [31:0] res_add,
    input  logic [31:0] res_mul,
    input  logic [31:0] res_div,
    input  logic [31:0] res_sqrt,
    input  logic [31:0] res_cvt,
    input  logic        div_done,
    input  logic        sqrt_done
);

    localparam int CNT_W = $clog2(DIV_TIMEOUT + 1);

    state_e             state_q, state_d;
    op_e                op_q, op_d, go_op;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic [31:0]        result_q, result_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               fregwb_q, fregwb_d;
    logic               err_q, err_d;
    logic               sub_q, sub_d;
    logic               ftoi_q, ftoi_d;
    logic [N_UNITS-1:0] unit_go_q, unit_go_d;

    logic               cmp_eq, cmp_lt, cmp_le;
    logic               cmp_true;
    logic               done_sel;
    logic               op_wb_int;
    logic [31:0]        fixed_res;
    logic [31:0]        var_res;

    assign go_op = decode_op(funct7, funct3);

    fp_cmp u_cmp (
        .a  (a_q),
        .b  (b_q),
        .eq (cmp_eq),
        .lt (cmp_lt),
        .le (cmp_le)
    );

    // Result routing depends only on the latched op, never on live inputs.
    always_comb begin
        cmp_true  = cmp_le;
        fixed_res = res_add;
        case (op_q)
            OP_FEQ:  cmp_true = cmp_eq;
            OP_FLT:  cmp_true = cmp_lt;
            default: cmp_true = cmp_le;
        endcase
        case (op_q)
            OP_MUL:             fixed_res = res_mul;
            OP_CVTWS, OP_CVTSW: fixed_res = res_cvt;
            default:            fixed_res = res_add;
        endcase
        done_sel  = (op_q == OP_DIV) ? div_done : sqrt_done;
        var_res   = (op_q == OP_DIV) ? res_div  : res_sqrt;
        op_wb_int = writes_int(op_q);
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        valid_d   = 1'b0;
        fregwb_d  = 1'b0;
        err_d     = 1'b0;
        sub_d     = sub_q;
        ftoi_d    = ftoi_q;
        unit_go_d = '0;

        case (state_q)
            S_IDLE: begin
                if (fpu_go) begin
                    state_d   = S_ISSUE;
                    op_d      = go_op;
                    a_d       = x1;
                    b_d       = x2;
                    sub_d     = (go_op == OP_SUB);
                    ftoi_d    = (go_op == OP_CVTWS);
                    // Registered so the unit pulse lines up with the ISSUE cycle
                    unit_go_d = unit_mask(go_op);
                end
            end

            S_ISSUE: begin
                case (op_q)
                    OP_ADD, OP_SUB: begin
                        state_d = S_COUNT;
                        cnt_d   = CNT_W'(LAT_ADD - 1);
                    end
                    OP_MUL: begin
                        state_d = S_COUNT;
                        cnt_d   = CNT_W'(LAT_MUL - 1);
                    end
                    OP_CVTWS, OP_CVTSW: begin
                        state_d = S_COUNT;
                        cnt_d   = CNT_W'(LAT_CVT - 1);
                    end
                    OP_DIV, OP_SQRT: begin
                        state_d = S_WAIT_DONE;
                        cnt_d   = '0;
                    end
                    OP_FEQ, OP_FLT, OP_FLE: begin
                        state_d = S_CAPTURE;
                    end
                    default: begin
                        state_d  = S_RESP;
                        result_d = '0;
                        err_d    = 1'b1;
                        valid_d  = 1'b1;
                    end
                endcase
            end

            S_COUNT: begin
                if (cnt_q == '0) begin
                    state_d  = S_RESP;
                    result_d = fixed_res;
                    valid_d  = 1'b1;
                    fregwb_d = op_wb_int;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_WAIT_DONE: begin
                // A strobe arriving on the final allowed cycle still wins over the timeout
                if (done_sel) begin
                    state_d  = S_RESP;
                    result_d = var_res;
                    valid_d  = 1'b1;
                    fregwb_d = op_wb_int;
                end else if (cnt_q == CNT_W'(DIV_TIMEOUT - 1)) begin
                    state_d  = S_RESP;
                    result_d = '0;
                    err_d    = 1'b1;
                    valid_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_CAPTURE: begin
                state_d  = S_RESP;
                result_d = {31'd0, cmp_true};
                valid_d  = 1'b1;
                fregwb_d = op_wb_int;
            end

            S_RESP: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            op_q      <= OP_ILL;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            fregwb_q  <= 1'b0;
            err_q     <= 1'b0;
            sub_q     <= 1'b0;
            ftoi_q    <= 1'b0;
            unit_go_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            fregwb_q  <= fregwb_d;
            err_q     <= err_d;
            sub_q     <= sub_d;
            ftoi_q    <= ftoi_d;
            unit_go_q <= unit_go_d;
        end
    end

    assign fpu_valid  = valid_q;
    assign fregwb     = fregwb_q;
    assign fpu_err    = err_q;
    assign fpu_result = result_q;
    assign busy       = (state_q != S_IDLE);
    assign u_a        = a_q;
    assign u_b        = b_q;
    assign unit_go    = unit_go_q;
    assign unit_sub   = sub_q;
    assign unit_ftoi  = ftoi_q;

endmodule

// File: tb/tb_fpu_seq.sv
// Scoreboard bench for fpu_seq: stimulus pushes expected responses, a monitor
// pops and compares them whenever fpu_valid is seen.
module tb_fpu_seq;

    localparam int LAT_ADD     = 2;
    localparam int LAT_MUL     = 2;
    localparam int LAT_CVT     = 1;
    localparam int DIV_TIMEOUT = 64;

    localparam int K_ADD = 0, K_SUB = 1, K_MUL = 2, K_DIV = 3, K_SQRT = 4, K_FEQ = 5;
    localparam int K_FLT = 6, K_FLE = 7, K_CVTWS = 8, K_CVTSW = 9, K_ILL = 10;

    logic        clk = 1'b0;
    logic        rstn;
    logic        fpu_go;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] x1, x2;
    logic        fpu_valid, fregwb, fpu_err, busy;
    logic [31:0] fpu_result, u_a, u_b;
    logic [4:0]  unit_go;
    logic        unit_sub, unit_ftoi;
    logic [31:0] res_add, res_mul, res_div, res_sqrt, res_cvt;
    logic        div_done, sqrt_done;

    typedef struct {
        int          cyc;
        logic [31:0] res;
        logic        wb;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_txn = 0;
    exp_t mon_e;

    logic [6:0]  t_f7 [12];
    logic [2:0]  t_f3 [12];

    fpu_seq #(
        .LAT_ADD     (LAT_ADD),
        .LAT_MUL     (LAT_MUL),
        .LAT_CVT     (LAT_CVT),
        .DIV_TIMEOUT (DIV_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .fpu_go     (fpu_go),
        .funct7     (funct7),
        .funct3     (funct3),
        .x1         (x1),
        .x2         (x2),
        .fpu_valid  (fpu_valid),
        .fregwb     (fregwb),
        .fpu_result (fpu_result),
        .fpu_err    (fpu_err),
        .busy       (busy),
        .u_a        (u_a),
        .u_b        (u_b),
        .unit_go    (unit_go),
        .unit_sub   (unit_sub),
        .unit_ftoi  (unit_ftoi),
        .res_add    (res_add),
        .res_mul    (res_mul),
        .res_div    (res_div),
        .res_sqrt   (res_sqrt),
        .res_cvt    (res_cvt),
        .div_done   (div_done),
        .sqrt_done  (sqrt_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Signed value with the same ordering as the float: +0 and -0 both map to 0.
    function automatic longint sm(input logic [31:0] x);
        longint m;
        m = longint'(x[30:0]);
        return x[31] ? -m : m;
    endfunction

    function automatic int classify(input logic [6:0] f7, input logic [2:0] f3);
        case (f7)
            7'b0000000: return K_ADD;
            7'b0000100: return K_SUB;
            7'b0001000: return K_MUL;
            7'b0001100: return K_DIV;
            7'b0101100: return K_SQRT;
            7'b1100000: return K_CVTWS;
            7'b1101000: return K_CVTSW;
            7'b1010000: begin
                if (f3 == 3'b010) return K_FEQ;
                if (f3 == 3'b001) return K_FLT;
                if (f3 == 3'b000) return K_FLE;
                return K_ILL;
            end
            default: return K_ILL;
        endcase
    endfunction

    // Cycle offsets are relative to the go cycle (rel 0); rel 1 is the issue cycle.
    task automatic run_op(input logic [6:0] f7, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input int done_at, input int stray_at,
                          input bit early_done, input bit extra_go);
        int          k, c0, lat, rel;
        logic [31:0] r;
        logic [4:0]  ug;
        bit          match_div;
        exp_t        e;
        k = classify(f7, f3);
        res_add  = $urandom;
        res_mul  = $urandom;
        res_div  = $urandom;
        res_sqrt = $urandom;
        res_cvt  = $urandom;
        match_div = (k != K_SQRT);
        e.err = 1'b0;
        e.wb  = (k == K_FEQ) || (k == K_FLT) || (k == K_FLE) || (k == K_CVTWS);
        ug    = 5'b00000;
        case (k)
            K_ADD, K_SUB: begin lat = 2 + LAT_ADD; r = res_add; ug = 5'b00001; end
            K_MUL:        begin lat = 2 + LAT_MUL; r = res_mul; ug = 5'b00010; end
            K_CVTWS, K_CVTSW: begin lat = 2 + LAT_CVT; r = res_cvt; ug = 5'b10000; end
            K_DIV, K_SQRT: begin
                ug = (k == K_DIV) ? 5'b00100 : 5'b01000;
                if (done_at >= 2 && done_at <= 1 + DIV_TIMEOUT) begin
                    lat = done_at + 1;
                    r   = (k == K_DIV) ? res_div : res_sqrt;
                end else begin
                    lat   = 2 + DIV_TIMEOUT;
                    r     = 32'd0;
                    e.err = 1'b1;
                end
            end
            K_FEQ: begin lat = 3; r = (sm(a) == sm(b)) ? 32'd1 : 32'd0; end
            K_FLT: begin lat = 3; r = (sm(a) <  sm(b)) ? 32'd1 : 32'd0; end
            K_FLE: begin lat = 3; r = (sm(a) <= sm(b)) ? 32'd1 : 32'd0; end
            default: begin lat = 2; r = 32'd0; e.err = 1'b1; end
        endcase
        c0    = cyc;
        e.cyc = c0 + lat;
        e.res = r;
        sb.push_back(e);
        funct7 = f7;
        funct3 = f3;
        x1     = a;
        x2     = b;
        fpu_go = 1'b1;
        step();
        rel = cyc - c0;
        while (rel <= lat) begin
            fpu_go = (rel == 1) && extra_go;
            if (rel == 1) begin
                funct7 = 7'($urandom);
                funct3 = 3'($urandom);
                x1     = $urandom;
                x2     = $urandom;
            end
            div_done  = match_div ? ((rel == done_at) || (early_done && rel == 1)) : (rel == stray_at);
            sqrt_done = match_div ? (rel == stray_at) : ((rel == done_at) || (early_done && rel == 1));
            if (rel == 1) begin
                @(negedge clk);
                check("unit_go", 32'(unit_go), 32'(ug));
                check("unit_sub", 32'(unit_sub), 32'(k == K_SUB));
                check("unit_ftoi", 32'(unit_ftoi), 32'(k == K_CVTWS));
                check("u_a", u_a, a);
                check("u_b", u_b, b);
                check("busy_issue", 32'(busy), 32'd1);
            end
            step();
            rel = cyc - c0;
        end
        fpu_go    = 1'b0;
        div_done  = 1'b0;
        sqrt_done = 1'b0;
    endtask

    task automatic reset_mid_op();
        funct7 = 7'b0000100;
        funct3 = 3'b000;
        x1     = $urandom;
        x2     = $urandom;
        fpu_go = 1'b1;
        step();
        fpu_go = 1'b0;
        step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(fpu_valid), 32'd0);
        check("rst_result", fpu_result, 32'd0);
        check("rst_u_a", u_a, 32'd0);
        check("rst_u_b", u_b, 32'd0);
        check("rst_unit_go", 32'(unit_go), 32'd0);
        check("rst_unit_sub", 32'(unit_sub), 32'd0);
        check("rst_flags", 32'({fregwb, fpu_err, unit_ftoi}), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            div_done  = (i == 1);
            sqrt_done = (i == 3);
            @(negedge clk);
            check("no_valid_after_reset", 32'(fpu_valid), 32'd0);
        end
        step();
        div_done  = 1'b0;
        sqrt_done = 1'b0;
        step();
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (fpu_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 32'(fpu_valid), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("valid_cycle", 32'(cyc), 32'(mon_e.cyc));
                    check("result", fpu_result, mon_e.res);
                    check("fregwb", 32'(fregwb), 32'(mon_e.wb));
                    check("fpu_err", 32'(fpu_err), 32'(mon_e.err));
                    n_txn++;
                    $display("txn %0d: cycle %0d result %h fregwb %0b err %0b",
                             n_txn, cyc, fpu_result, fregwb, fpu_err);
                end
            end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
                mon_e = sb.pop_front();
                check("valid_by_cycle", 32'(fpu_valid), 32'd1);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin : stim
        int          idx, d, s;
        logic [31:0] ra, rb;
        logic [6:0]  rf7;
        logic [2:0]  rf3;
        t_f7[0]  = 7'b0000000; t_f3[0]  = 3'b000;
        t_f7[1]  = 7'b0000100; t_f3[1]  = 3'b000;
        t_f7[2]  = 7'b0001000; t_f3[2]  = 3'b000;
        t_f7[3]  = 7'b0001100; t_f3[3]  = 3'b000;
        t_f7[4]  = 7'b0101100; t_f3[4]  = 3'b000;
        t_f7[5]  = 7'b1010000; t_f3[5]  = 3'b010;
        t_f7[6]  = 7'b1010000; t_f3[6]  = 3'b001;
        t_f7[7]  = 7'b1010000; t_f3[7]  = 3'b000;
        t_f7[8]  = 7'b1100000; t_f3[8]  = 3'b000;
        t_f7[9]  = 7'b1101000; t_f3[9]  = 3'b000;
        t_f7[10] = 7'b1010000; t_f3[10] = 3'b011;
        t_f7[11] = 7'b1111111; t_f3[11] = 3'b000;

        rstn = 1'b0; fpu_go = 1'b0; funct7 = '0; funct3 = '0; x1 = '0; x2 = '0;
        res_add = '0; res_mul = '0; res_div = '0; res_sqrt = '0; res_cvt = '0;
        div_done = 1'b0; sqrt_done = 1'b0;
        step();
        step();
        @(negedge clk);
        check("reset_valid", 32'(fpu_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_unit_go", 32'(unit_go), 32'd0);
        check("reset_result", fpu_result, 32'd0);
        check("reset_operands", u_a | u_b, 32'd0);
        check("reset_flags", 32'({fregwb, fpu_err, unit_sub, unit_ftoi}), 32'd0);
        step();
        rstn = 1'b1;
        step();

        run_op(7'b0000000, 3'b000, 32'h3F800000, 32'h40000000, -1, -1, 1'b0, 1'b0);
        run_op(7'b1010000, 3'b001, 32'hBF800000, 32'h3F800000, -1, -1, 1'b0, 1'b0);
        run_op(7'b1010000, 3'b010, 32'h80000000, 32'h00000000, -1, -1, 1'b0, 1'b0);
        run_op(7'b1010000, 3'b000, 32'hC0000000, 32'hC0400000, -1, -1, 1'b0, 1'b0);
        run_op(7'b0001100, 3'b000, $urandom, $urandom, 10, 5, 1'b1, 1'b0);
        run_op(7'b0101100, 3'b000, $urandom, $urandom, -1, 3, 1'b0, 1'b0);
        run_op(7'b1111111, 3'b000, $urandom, $urandom, -1, -1, 1'b0, 1'b1);
        run_op(7'b1010000, 3'b011, $urandom, $urandom, -1, -1, 1'b0, 1'b0);
        run_op(7'b0000100, 3'b000, $urandom, $urandom, 2, 3, 1'b0, 1'b1);
        run_op(7'b0001000, 3'b000, $urandom, $urandom, -1, -1, 1'b0, 1'b0);
        run_op(7'b1100000, 3'b000, $urandom, $urandom, -1, -1, 1'b0, 1'b0);
        run_op(7'b1101000, 3'b000, $urandom, $urandom, -1, -1, 1'b0, 1'b0);
        reset_mid_op();

        for (int i = 0; i < 40; i++) begin
            idx = int'($urandom_range(0, 11));
            rf7 = t_f7[idx];
            rf3 = t_f3[idx];
            if (idx == 11) begin
                rf7 = 7'($urandom);
                rf3 = 3'($urandom);
            end
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: begin ra = {1'($urandom), 31'd0}; rb = {1'($urandom), 31'd0}; end
                2: rb = {~ra[31], ra[30:0]};
                default: ;
            endcase
            d = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 25));
            s = int'($urandom_range(0, 25));
            run_op(rf7, rf3, ra, rb, d, s, 1'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (4) step();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
